// File: rtl/fixed_point_alu.sv
// fixed_point_alu: handshaked signed Q(WIDTH-FBITS).FBITS add/sub/mul/sqrt unit.
// Build option FXP_SATURATE_EN clamps overflowing ADD/SUB/MUL results instead of wrapping.
//
// state | meaning
// IDLE  | ready for a request, or dispatching the request just accepted
// MUL   | shift-add multiply, MUL_BITS multiplier bits per cycle
// SQRT  | restoring square root, one root bit per cycle
// DONE  | result valid, held until out_ready
`timescale 1ns/1ps
module fixed_point_alu #(
    parameter int WIDTH    = 32,
    parameter int FBITS    = 10,
    parameter int MUL_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    localparam int N     = WIDTH / MUL_BITS;
    localparam int RW    = WIDTH + FBITS;
    localparam int ITER  = RW / 2;
    localparam int CNT_W = $clog2(((N > ITER) ? N : ITER) + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ITER = CNT_W'(ITER);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;

    localparam logic [2*WIDTH-1:0] POS_LIMIT = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [2*WIDTH-1:0] NEG_LIMIT = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

`ifdef FXP_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, SQRT, DONE} state_t;

    state_t             state, state_nxt;
    logic               pending;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] a_sh, acc;
    logic [WIDTH-1:0]   b_sh;
    logic [RW-1:0]      rad;
    logic [ITER:0]      rem;
    logic [ITER-1:0]    root;
    logic [CNT_W-1:0]   cnt;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] wrapped,
                                               input logic ovf, input logic neg);
        if (SATURATE && ovf)
            return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return wrapped;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // ADD/SUB: true result sign equals operand_1 sign whenever overflow occurs
    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf;
    assign sum     = a_q + b_q;
    assign diff    = a_q - b_q;
    assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);

    logic [2*WIDTH-1:0] pp, acc_nxt, mag;
    logic [WIDTH-1:0]   mul_wrap;
    logic               mul_ovf;

    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_BITS; i++)
            if (b_sh[i]) pp = pp + (a_sh << i);
    end

    assign acc_nxt  = acc + pp;
    assign mag      = acc_nxt >> FBITS;
    assign mul_ovf  = neg_q ? (mag > NEG_LIMIT) : (mag > POS_LIMIT);
    assign mul_wrap = neg_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];

    // Remainder never exceeds twice the partial root, so ITER+1 bits hold it
    logic [ITER+2:0] rem_t, trial;
    logic [ITER:0]   rem_sub, rem_nxt;
    logic [ITER-1:0] root_nxt;
    logic            sq_ge;

    assign rem_t    = {rem, rad[RW-1 -: 2]};
    assign trial    = {1'b0, root, 2'b01};
    assign sq_ge    = rem_t >= trial;
    assign rem_sub  = rem_t[ITER:0] - trial[ITER:0];
    assign rem_nxt  = sq_ge ? rem_sub : rem_t[ITER:0];
    assign root_nxt = {root[ITER-2:0], sq_ge};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pending) begin
                    case (op_q)
                        OP_MUL:  state_nxt = MUL;
                        2'b11:   state_nxt = a_q[WIDTH-1] ? DONE : SQRT;
                        default: state_nxt = DONE;
                    endcase
                end
            end
            MUL:     if (cnt == CNT_ONE) state_nxt = DONE;
            SQRT:    if (cnt == CNT_ONE) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = !reset && (state == IDLE) && !pending;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            rad      <= '0;
            rem      <= '0;
            root     <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                pending <= 1'b1;
                op_q    <= op;
                a_q     <= operand_1;
                b_q     <= operand_2;
            end
            case (state)
                IDLE: begin
                    if (pending) begin
                        pending <= 1'b0;
                        case (op_q)
                            OP_ADD: begin
                                result   <= clamp(sum, add_ovf, a_q[WIDTH-1]);
                                overflow <= add_ovf;
                            end
                            OP_SUB: begin
                                result   <= clamp(diff, sub_ovf, a_q[WIDTH-1]);
                                overflow <= sub_ovf;
                            end
                            OP_MUL: begin
                                neg_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                                a_sh  <= {{WIDTH{1'b0}}, abs_val(a_q)};
                                b_sh  <= abs_val(b_q);
                                acc   <= '0;
                                cnt   <= CNT_N;
                            end
                            default: begin
                                if (a_q[WIDTH-1]) begin
                                    result   <= '0;
                                    overflow <= 1'b1;
                                end else begin
                                    rad  <= {a_q, {FBITS{1'b0}}};
                                    rem  <= '0;
                                    root <= '0;
                                    cnt  <= CNT_ITER;
                                end
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh << MUL_BITS;
                    b_sh <= b_sh >> MUL_BITS;
                    cnt  <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result   <= clamp(mul_wrap, mul_ovf, neg_q);
                        overflow <= mul_ovf;
                    end
                end
                SQRT: begin
                    rad  <= rad << 2;
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    cnt  <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result   <= {{(WIDTH-ITER){1'b0}}, root_nxt};
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_alu.sv
// tb_fixed_point_alu: vector table plus model-driven random ops through a result scoreboard,
// with backpressure and mid-operation reset sequences. Honours FXP_SATURATE_EN.
`timescale 1ns/1ps
module tb_fixed_point_alu;
`ifdef FXP_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [31:0] MAXP = 32'h7FFF_FFFF;
    localparam logic [31:0] MAXN = 32'h8000_0000;
    localparam longint LMAX = (longint'(1) <<< 31) - 1;
    localparam longint LMIN = -(longint'(1) <<< 31);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    fixed_point_alu #(.WIDTH(32), .FBITS(10), .MUL_BITS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .operand_1(operand_1), .operand_2(operand_2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic add_vec(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic ovf,
                           input int lat);
        vec_t v;
        v.name = name; v.op = o; v.a = a; v.b = b; v.res = res; v.ovf = ovf; v.lat = lat;
        vecs.push_back(v);
    endtask

    function automatic longint isqrt(input longint x);
        longint r = 0;
        longint t;
        for (int bit_i = 22; bit_i >= 0; bit_i--) begin
            t = r | (longint'(1) <<< bit_i);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    function automatic longint true_val(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
        longint sa;
        longint sb_v;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        case (o)
            2'b00:   return sa + sb_v;
            2'b01:   return sa - sb_v;
            2'b10:   return (sa * sb_v) / 1024;
            default: return (sa < 0) ? 0 : isqrt(sa * 1024);
        endcase
    endfunction

    function automatic logic model_ovf(input logic [1:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        longint q;
        if (o == 2'b11) return a[31];
        q = true_val(o, a, b);
        return (q > LMAX) || (q < LMIN);
    endfunction

    function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint q;
        q = true_val(o, a, b);
        if (o != 2'b11 && SAT && model_ovf(o, a, b)) return (q < 0) ? MAXN : MAXP;
        return q[31:0];
    endfunction

    function automatic int lat_of(input logic [1:0] o, input logic [31:0] a);
        if (o == 2'b10) return 9;
        if (o == 2'b11) return a[31] ? 1 : 22;
        return 1;
    endfunction

    // Issues one request, then waits for and scores its result; hold > 0 stalls the consumer.
    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic eo,
                         input int el, input int hold);
        exp_t e;
        int   lat;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL %s_accept: actual in_ready 0 required 1 within 50 cycles", name);
            return;
        end
        in_valid  = 1'b1;
        op        = o;
        operand_1 = a;
        operand_2 = b;
        out_ready = (hold == 0);
        e.name = name; e.res = er; e.ovf = eo; e.lat = el;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        op        = ~o;
        operand_1 = $urandom;
        operand_2 = $urandom;
        check({name, "_busy_in_ready"}, {31'b0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: actual out_valid 0 required 1 within 100 cycles", e.name);
            out_ready = 1'b1;
            return;
        end
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_overflow"}, {31'b0, overflow}, {31'b0, e.ovf});
        check({e.name, "_latency"}, lat, e.lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({e.name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            check({e.name, "_hold_result"}, result, e.res);
            check({e.name, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({e.name, "_retire_valid"}, {31'b0, out_valid}, 32'd0);
        check({e.name, "_retire_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        bit          got;

        add_vec("add_basic",    2'd0, 32'd1536,      32'd2304,      32'd3840,      1'b0, 1);
        add_vec("sub_basic",    2'd1, 32'd1536,      32'd2304,      32'hFFFF_FD00, 1'b0, 1);
        add_vec("add_neg",      2'd0, 32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFFF_F800, 1'b0, 1);
        add_vec("add_ovf",      2'd0, 32'h7FFF_FFFF, 32'd1,         SAT ? MAXP : MAXN, 1'b1, 1);
        add_vec("sub_ovf_neg",  2'd1, 32'h8000_0000, 32'd1,         SAT ? MAXN : MAXP, 1'b1, 1);
        add_vec("sub_ovf_pos",  2'd1, 32'd0,         32'h8000_0000, SAT ? MAXP : MAXN, 1'b1, 1);
        add_vec("mul_basic",    2'd2, 32'd3072,      32'hFFFF_F600, 32'hFFFF_E200, 1'b0, 9);
        add_vec("mul_trunc_p",  2'd2, 32'd3,         32'd512,       32'd1,         1'b0, 9);
        add_vec("mul_trunc_n",  2'd2, 32'hFFFF_FFFD, 32'd512,       32'hFFFF_FFFF, 1'b0, 9);
        add_vec("mul_fit",      2'd2, 32'h0010_0000, 32'h0010_0000, 32'h4000_0000, 1'b0, 9);
        add_vec("mul_ovf_pos",  2'd2, 32'h0020_0000, 32'h0010_0000, SAT ? MAXP : MAXN, 1'b1, 9);
        add_vec("mul_min_ok",   2'd2, 32'hFFE0_0000, 32'h0010_0000, 32'h8000_0000, 1'b0, 9);
        add_vec("mul_min_neg1", 2'd2, 32'h8000_0000, 32'hFFFF_FC00, SAT ? MAXP : MAXN, 1'b1, 9);
        add_vec("sqrt_16",      2'd3, 32'd16384,     32'd0,         32'd4096,      1'b0, 22);
        add_vec("sqrt_2",       2'd3, 32'd2048,      32'd77,        32'd1448,      1'b0, 22);
        add_vec("sqrt_zero",    2'd3, 32'd0,         32'd0,         32'd0,         1'b0, 22);
        add_vec("sqrt_neg",     2'd3, 32'hFFFF_FC00, 32'd5,         32'd0,         1'b1, 1);

        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_overflow", {31'b0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("release_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++)
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].ovf, vecs[i].lat, 0);

        do_op("sqrt_max", 2'd3, MAXP, 32'd0, model_res(2'd3, MAXP, 32'd0),
              model_ovf(2'd3, MAXP, 32'd0), 22, 0);
        for (int i = 0; i < 12; i++) begin
            o = 2'(i % 4);
            a = 32'($signed($urandom) >>> $urandom_range(0, 20));
            b = 32'($signed($urandom) >>> $urandom_range(0, 20));
            do_op($sformatf("rand%0d", i), o, a, b, model_res(o, a, b), model_ovf(o, a, b),
                  lat_of(o, a), 0);
        end

        do_op("mul_backpressure", 2'd2, 32'd3072, 32'hFFFF_F600, 32'hFFFF_E200, 1'b0, 9, 5);

        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        check("midrst_accept_ready", {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        op        = 2'd3;
        operand_1 = 32'd16384;
        operand_2 = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_overflow", {31'b0, overflow}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_held_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_release_ready", {31'b0, in_ready}, 32'd1);
        repeat (25) @(posedge clk);
        #1;
        check("midrst_no_late_valid", {31'b0, out_valid}, 32'd0);
        do_op("add_after_reset", 2'd0, 32'd1536, 32'd2304, 32'd3840, 1'b0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual simulation still running required finished");
        $fatal(1, "watchdog expired");
    end
endmodule
